// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM for a multi-cycle MIPS datapath. Walks one instruction
//   through fetch / decode / execute / memory / write-back and stalls on the
//   shared instruction/data memory until it reports ready.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous, active-low reset (forces every output to 0)
//   opcode_i         IR[31:26], stable from DECODE onward
//   mem_ready_i      memory finished the current access this cycle
//   pc_write_o       unconditional PC load
//   pc_write_cond_o  PC load when ALU zero is set (beq)
//   pc_src_o         PC source: 0 ALU result, 1 ALUOut, 2 jump target
//   i_or_d_o         memory address: 0 PC, 1 ALUOut
//   mem_read_o       memory read request
//   mem_write_o      memory write request
//   ir_write_o       load IR
//   reg_write_o      register file write
//   reg_dst_o        destination: 0 rt, 1 rd
//   mem_to_reg_o     write-back source: 0 ALUOut, 1 MDR
//   alu_src_a_o      ALU A: 0 PC, 1 register A
//   alu_src_b_o      ALU B: 0 reg B, 1 const 4, 2 sext imm, 3 sext imm << 2
//   alu_op_o         class code for the ALU control decoder
//   state_o          current state (debug)
//   illegal_o        one-cycle pulse in DECODE on an unsupported opcode
module multicycle_ctrl #(
  parameter int OP_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic [1:0]      pc_src_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            mem_to_reg_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [3:0]      alu_op_o,
  output logic [3:0]      state_o,
  output logic            illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_R    = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;

  state_t state_q, state_d;
  logic   op_legal;

  assign op_legal = (opcode_i == OP_RTYPE) || (opcode_i == OP_LW) ||
                    (opcode_i == OP_SW)    || (opcode_i == OP_ADDI) ||
                    (opcode_i == OP_BEQ)   || (opcode_i == OP_J);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) state_d = S_MEMADR;
        else if (opcode_i == OP_RTYPE)                 state_d = S_EXEC;
        else if (opcode_i == OP_ADDI)                  state_d = S_ADDIEX;
        else if (opcode_i == OP_BEQ)                   state_d = S_BRANCH;
        else if (opcode_i == OP_J)                     state_d = S_JUMP;
        else                                           state_d = S_FETCH;
      end
      S_MEMADR: state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;  // write-back, branch, jump, unused codes
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Output decode. Everything is gated by rst_i so that a reset asserted
  // mid-instruction suppresses writes within the very same cycle. The FETCH
  // strobes follow mem_ready_i combinationally so the IR/PC load exactly once
  // per fetch regardless of wait cycles.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'd0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    alu_op_o        = ALU_ADD;
    illegal_o       = 1'b0;
    state_o         = 4'd0;
    if (rst_i) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'd1;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = 2'd3;
          illegal_o   = ~op_legal;
        end
        S_MEMADR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
        end
        S_MEMRD: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
        end
        S_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEMWR: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_R;
        end
        S_ALUWB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = ALU_SUB;
          pc_write_cond_o = 1'b1;
          pc_src_o        = 2'd1;
        end
        S_JUMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = 2'd2;
        end
        S_ADDIEX: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
          alu_op_o    = ALU_ADDI;
        end
        S_ADDIWB: reg_write_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op, state;

  multicycle_ctrl #(.OP_W(6)) dut (
    .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .pc_src_o(pc_src),
    .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .state_o(state), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  // Packed view of all control outputs (state_o checked separately)
  logic [18:0] act;
  assign act = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_op, illegal};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};
  endfunction

  // Expected control word for a given state as listed in the state table
  function automatic logic [18:0] exp_out(input logic [3:0] s, input logic r, input logic [5:0] op);
    logic pw, pwc, iord, mr, mw, irw, rw, rd, m2r, asa, ill;
    logic [1:0] ps, asb;
    logic [3:0] aop;
    {pw, pwc, iord, mr, mw, irw, rw, rd, m2r, asa, ill} = '0;
    ps = 2'd0; asb = 2'd0; aop = 4'd0;
    case (s)
      4'd0:  begin mr = 1; asb = 2'd1; irw = r; pw = r; end
      4'd1:  begin asb = 2'd3; ill = !is_legal(op); end
      4'd2:  begin asa = 1; asb = 2'd2; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 4'b0010; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 4'b0100; pwc = 1; ps = 2'd1; end
      4'd9:  begin pw = 1; ps = 2'd2; end
      4'd10: begin asa = 1; asb = 2'd2; aop = 4'b0011; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, ps, iord, mr, mw, irw, rw, rd, m2r, asa, asb, aop, ill};
  endfunction

  // Reference schedule: the instruction's path through the cycle phases,
  // with the memory-ready value the bench will drive in each cycle.
  logic [3:0] sq[$];
  logic       rq[$];
  logic [3:0] obs[$];

  task automatic push(input logic [3:0] s, input logic r);
    sq.push_back(s);
    rq.push_back(r);
  endtask

  task automatic build(input logic [5:0] op, input int fw, input int mw);
    sq.delete(); rq.delete();
    for (int k = 0; k < fw; k++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom_range(1)));
    case (op)
      6'b100011: begin
        push(4'd2, 1'($urandom_range(1)));
        for (int k = 0; k < mw; k++) push(4'd3, 1'b0);
        push(4'd3, 1'b1);
        push(4'd4, 1'($urandom_range(1)));
      end
      6'b101011: begin
        push(4'd2, 1'($urandom_range(1)));
        for (int k = 0; k < mw; k++) push(4'd5, 1'b0);
        push(4'd5, 1'b1);
      end
      6'b000000: begin push(4'd6, 1'($urandom_range(1))); push(4'd7, 1'($urandom_range(1))); end
      6'b001000: begin push(4'd10, 1'($urandom_range(1))); push(4'd11, 1'($urandom_range(1))); end
      6'b000100: push(4'd8, 1'($urandom_range(1)));
      6'b000010: push(4'd9, 1'($urandom_range(1)));
      default: ;
    endcase
  endtask

  // Runs one instruction starting in FETCH, one cycle per schedule entry.
  // Inputs change 1ns after the rising edge; outputs sampled at the falling edge.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic [47:0] exp_seq, input int exp_len, input bit chk_seq);
    string s;
    build(op, fw, mw);
    obs.delete();
    for (int i = 0; i < sq.size(); i++) begin
      opcode = op;
      mem_ready = rq[i];
      #4;
      chk("state", 32'(state), 32'(sq[i]));
      chk("outputs", 32'(act), 32'(exp_out(sq[i], rq[i], op)));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      chk("pcw_excl", 32'(pc_write & pc_write_cond), 32'd0);
      obs.push_back(state);
      @(posedge clk); #1;
    end
    s = "";
    foreach (obs[i]) s = {s, $sformatf("%0d,", obs[i])};
    $display("instr op=%b fwait=%0d mwait=%0d states=%s0", op, fw, mw, s);
    if (chk_seq) begin
      chk("seq_len", 32'(obs.size()), 32'(exp_len));
      for (int k = 0; k < exp_len && k < obs.size(); k++)
        chk("seq_state", 32'(obs[k]), 32'(exp_seq[4*k +: 4]));
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    int          fw;
    int          mw;
    int          len;
    logic [47:0] seq;  // nibble k = k-th state
  } vec_t;

  vec_t       vt[7];
  logic [5:0] legal_ops[6];
  logic [5:0] bad_ops[4];

  initial begin
    vt[0] = '{6'b000000, 0, 0, 4,  48'h7610};        // R-type 0,1,6,7
    vt[1] = '{6'b100011, 2, 3, 10, 48'h4333321000};  // lw with waits
    vt[2] = '{6'b000100, 0, 0, 3,  48'h810};         // beq
    vt[3] = '{6'b000010, 0, 0, 3,  48'h910};         // j
    vt[4] = '{6'b111111, 0, 0, 2,  48'h10};          // illegal
    vt[5] = '{6'b101011, 0, 0, 4,  48'h5210};        // sw
    vt[6] = '{6'b001000, 0, 0, 4,  48'hBA10};        // addi
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};
    bad_ops   = '{6'b111111, 6'b000001, 6'b100010, 6'b000101};

    rst_n = 1'b0; opcode = 6'b0; mem_ready = 1'b1;

    // Reset: all outputs zero while rst is low
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(1));
      #4;
      chk("reset_outputs", 32'(act), 32'd0);
      chk("reset_state", 32'(state), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 7; v++)
      run_instr(vt[v].op, vt[v].fw, vt[v].mw, vt[v].seq, vt[v].len, 1'b1);

    // Reset during MEMWR while the write is pending
    opcode = 6'b101011; mem_ready = 1'b1;
    #4; chk("rst_seq_fetch", 32'(state), 32'd0);
    @(posedge clk); #1; #4; chk("rst_seq_decode", 32'(state), 32'd1);
    @(posedge clk); #1; #4; chk("rst_seq_memadr", 32'(state), 32'd2);
    @(posedge clk); #1; mem_ready = 1'b0;
    #4; chk("rst_seq_memwr", 32'(mem_write), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_memwr_write", 32'(mem_write), 32'd0);
    chk("rst_memwr_outputs", 32'(act), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    #3;
    chk("rst_restart_state", 32'(state), 32'd0);
    chk("rst_restart_read", 32'(mem_read), 32'd1);
    chk("rst_restart_irw", 32'(ir_write), 32'd0);
    @(posedge clk); #1;
    run_instr(6'b000000, 1, 0, 48'h0, 0, 1'b0);

    // Randomized instruction stream against the schedule model
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      if ($urandom_range(9) == 0) op = bad_ops[$urandom_range(3)];
      else                        op = legal_ops[$urandom_range(5)];
      run_instr(op, $urandom_range(3), $urandom_range(3), 48'h0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences one instruction through fetch, decode, execute, memory and write-back over several cycles, and stalls on a shared instruction/data memory with a ready handshake. It drives every datapath mux and write enable. It supplies `alu_op_o` to the existing ALU control decoder, which translates it together with `funct` into the ALU operation.

## Interface
Parameters:
- `OP_W`, default 6: opcode width.

Ports:
- `clk_i`, input, 1: single clock; all state changes on the rising edge.
- `rst_i`, input, 1: synchronous, active-low reset.
- `opcode_i`, input, 6: `IR[31:26]`; must be stable from DECODE onward.
- `mem_ready_i`, input, 1: memory has completed the current read or write this cycle.
- `pc_write_o`, output, 1: unconditional PC load.
- `pc_write_cond_o`, output, 1: PC load if ALU zero is set (beq).
- `pc_src_o`, output, 2: PC source. 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- `i_or_d_o`, output, 1: memory address source. 0 = PC, 1 = ALUOut.
- `mem_read_o`, output, 1: memory read request.
- `mem_write_o`, output, 1: memory write request.
- `ir_write_o`, output, 1: load IR.
- `reg_write_o`, output, 1: register file write.
- `reg_dst_o`, output, 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg_o`, output, 1: write-back source. 0 = ALUOut, 1 = MDR.
- `alu_src_a_o`, output, 1: ALU A operand. 0 = PC, 1 = register A.
- `alu_src_b_o`, output, 2: ALU B operand. 0 = register B, 1 = 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `alu_op_o`, output, 4: encoding consumed by the ALU control decoder.
- `state_o`, output, 4: current state, for debug and verification.
- `illegal_o`, output, 1: one-cycle pulse on an unsupported opcode.

## Operation
Supported opcodes:
- R-type 000000
- lw 100011
- sw 101011
- addi 001000
- beq 000100
- j 000010

`alu_op_o` encodings:
- 0000: add (fetch, decode, address calculation)
- 0010: R-type, funct decides
- 0011: addi
- 0100: beq (subtract)

States (`state_o` value) and their outputs. Any output not listed is 0; `alu_op_o` defaults to 0000.
- FETCH (0): `mem_read_o`=1, `i_or_d_o`=0, `alu_src_a_o`=0, `alu_src_b_o`=1, `pc_src_o`=0.
  - `ir_write_o` and `pc_write_o` equal `mem_ready_i`.
  - Stay in FETCH while `mem_ready_i`=0; go to DECODE when it is 1.
- DECODE (1): `alu_src_a_o`=0, `alu_src_b_o`=3 (branch target into ALUOut).
  - Next state by opcode: lw/sw → MEMADR, R-type → EXEC, addi → ADDIEX, beq → BRANCH, j → JUMP.
  - Any other opcode → FETCH, with `illegal_o`=1 for this cycle.
- MEMADR (2): `alu_src_a_o`=1, `alu_src_b_o`=2. Next is MEMRD for lw, MEMWR for sw.
- MEMRD (3): `mem_read_o`=1, `i_or_d_o`=1. Hold until `mem_ready_i`, then go to MEMWB.
- MEMWB (4): `reg_write_o`=1, `mem_to_reg_o`=1, `reg_dst_o`=0. Next is FETCH.
- MEMWR (5): `mem_write_o`=1, `i_or_d_o`=1. Hold until `mem_ready_i`, then go to FETCH.
- EXEC (6): `alu_src_a_o`=1, `alu_src_b_o`=0, `alu_op_o`=0010. Next is ALUWB.
- ALUWB (7): `reg_write_o`=1, `reg_dst_o`=1, `mem_to_reg_o`=0. Next is FETCH.
- BRANCH (8): `alu_src_a_o`=1, `alu_src_b_o`=0, `alu_op_o`=0100, `pc_write_cond_o`=1, `pc_src_o`=1. Next is FETCH.
- JUMP (9): `pc_write_o`=1, `pc_src_o`=2. Next is FETCH.
- ADDIEX (10): `alu_src_a_o`=1, `alu_src_b_o`=2, `alu_op_o`=0011. Next is ADDIWB.
- ADDIWB (11): `reg_write_o`=1, `reg_dst_o`=0, `mem_to_reg_o`=0. Next is FETCH.
- Unused codes 12–15: next state is FETCH; all outputs 0.

Rules:
- `mem_read_o` and `mem_write_o` are never high in the same cycle.
- At most one of `pc_write_o` and `pc_write_cond_o` is high.

## Timing
- Reset: if `rst_i`=0 at a rising edge, the state becomes FETCH. While `rst_i`=0, all outputs are forced to 0, including `mem_read_o`, `state_o` and `illegal_o`.
- Reset mid-instruction aborts the instruction. No register or memory write occurs in the reset cycle.
- The first FETCH read is issued in the first cycle with `rst_i`=1.
- Latency with zero-wait memory (`mem_ready_i` tied to 1), FETCH to next FETCH:
  - lw: 5 cycles
  - R-type, addi, sw: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each memory wait cycle adds 1 cycle. During a wait, every output holds its value except the ready-gated strobes.
- `ir_write_o` and `pc_write_o` in FETCH are combinational on `mem_ready_i`. They are high for exactly one cycle per fetch.
- Memory request signals stay asserted continuously until the cycle in which `mem_ready_i`=1.

## Test plan
- Zero-wait R-type (opcode 000000) → `state_o` sequence 0,1,6,7,0. `alu_op_o`=0010 in EXEC. `reg_write_o`=1 with `reg_dst_o`=1 in state 7 only.
- lw with `mem_ready_i` low for 2 cycles in FETCH and 3 cycles in MEMRD → sequence 0,0,0,1,2,3,3,3,3,4,0. `ir_write_o` pulses once. `reg_write_o`=1 with `mem_to_reg_o`=1 in state 4.
- beq then j → sequences 0,1,8,0 and 0,1,9,0. `pc_write_cond_o`=1 with `pc_src_o`=1 in state 8. `pc_write_o`=1 with `pc_src_o`=2 in state 9.
- Illegal opcode 111111 → 0,1,0. `illegal_o` is high in the DECODE cycle only. No write enables assert.
- `rst_i` driven low during MEMWR with `mem_write_o` high → `mem_write_o`=0 in that cycle. `state_o`=0 after the edge. Fetch restarts when `rst_i` returns to 1.
- sw and addi zero-wait → 0,1,2,5,0 and 0,1,10,11,0. `alu_op_o`=0011 in state 10. `mem_read_o` and `mem_write_o` are never both high.
